// File: rtl/ram_dp_sync_be.sv
// True dual-port synchronous RAM with per-byte write enables, selectable same-port
// read-during-write, 1- or 2-stage read pipeline, collision counting and range flagging.
module ram_dp_sync_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 256,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cs_0,
    input  logic                    we_0,
    input  logic [DATA_WIDTH/8-1:0] be_0,
    input  logic [ADDR_WIDTH-1:0]   address_0,
    input  logic [DATA_WIDTH-1:0]   wdata_0,
    output logic [DATA_WIDTH-1:0]   rdata_0,
    output logic                    rvalid_0,
    output logic                    addr_err_0,
    input  logic                    cs_1,
    input  logic                    we_1,
    input  logic [DATA_WIDTH/8-1:0] be_1,
    input  logic [ADDR_WIDTH-1:0]   address_1,
    input  logic [DATA_WIDTH-1:0]   wdata_1,
    output logic [DATA_WIDTH-1:0]   rdata_1,
    output logic                    rvalid_1,
    output logic                    addr_err_1,
    output logic                    collision,
    output logic [CNT_WIDTH-1:0]    coll_cnt
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic                  cs     [2];
    logic                  we     [2];
    logic [NB-1:0]         be     [2];
    logic [ADDR_WIDTH-1:0] addr   [2];
    logic [DATA_WIDTH-1:0] wdata  [2];
    logic                  in_rng [2];
    logic                  wr     [2];
    logic [DATA_WIDTH-1:0] old_w  [2];
    logic [DATA_WIDTH-1:0] new_w  [2];
    logic                  acc_v  [2];
    logic                  acc_e  [2];
    logic [DATA_WIDTH-1:0] acc_d  [2];
    logic                  s1_v_q [2];
    logic                  s1_e_q [2];
    logic [DATA_WIDTH-1:0] s1_d_q [2];
    logic                  coll_d;
    logic                  coll_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_comb begin
        cs[0]    = cs_0;      cs[1]    = cs_1;
        we[0]    = we_0;      we[1]    = we_1;
        be[0]    = be_0;      be[1]    = be_1;
        addr[0]  = address_0; addr[1]  = address_1;
        wdata[0] = wdata_0;   wdata[1] = wdata_1;
    end

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            in_rng[p] = 32'(addr[p]) < RAM_DEPTH;
            wr[p]     = cs[p] & we[p] & in_rng[p];
            old_w[p]  = in_rng[p] ? mem[addr[p]] : '0;
        end
    end

    // new_w is the word as it will stand after this edge, including a collision merge
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            new_w[p] = old_w[p];
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr[1] && (addr[1] == addr[p]) && be[1][b])
                    new_w[p][8*b +: 8] = wdata[1][8*b +: 8];
                if (wr[0] && (addr[0] == addr[p]) && be[0][b])
                    new_w[p][8*b +: 8] = wdata[0][8*b +: 8];
            end
            acc_v[p] = cs[p] & (~we[p] | (RDW_MODE == 1));
            acc_e[p] = cs[p] & ~in_rng[p];
            acc_d[p] = we[p] ? new_w[p] : old_w[p];
        end
        coll_d = wr[0] & wr[1] & (addr[0] == addr[1]);
        cnt_d  = (coll_d && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    // Port 1 bytes are scheduled first so port 0 overrides them on a collision
    always_ff @(posedge clk) begin
        if (wr[1]) begin
            for (int unsigned b = 0; b < NB; b++)
                if (be[1][b]) mem[addr[1]][8*b +: 8] <= wdata[1][8*b +: 8];
        end
        if (wr[0]) begin
            for (int unsigned b = 0; b < NB; b++)
                if (be[0][b]) mem[addr[0]][8*b +: 8] <= wdata[0][8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < 2; p++) begin
                s1_v_q[p] <= 1'b0;
                s1_e_q[p] <= 1'b0;
                s1_d_q[p] <= '0;
            end
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                s1_v_q[p] <= acc_v[p];
                s1_e_q[p] <= acc_e[p];
                if (acc_v[p]) s1_d_q[p] <= acc_d[p];
            end
            coll_q <= coll_d;
            cnt_q  <= cnt_d;
        end
    end

    assign collision = coll_q;
    assign coll_cnt  = cnt_q;

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_v_q [2];
        logic                  s2_e_q [2];
        logic [DATA_WIDTH-1:0] s2_d_q [2];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    s2_v_q[p] <= 1'b0;
                    s2_e_q[p] <= 1'b0;
                    s2_d_q[p] <= '0;
                end
            end else begin
                for (int unsigned p = 0; p < 2; p++) begin
                    s2_v_q[p] <= s1_v_q[p];
                    s2_e_q[p] <= s1_e_q[p];
                    if (s1_v_q[p]) s2_d_q[p] <= s1_d_q[p];
                end
            end
        end

        assign rdata_0    = s2_d_q[0];
        assign rvalid_0   = s2_v_q[0];
        assign addr_err_0 = s2_e_q[0];
        assign rdata_1    = s2_d_q[1];
        assign rvalid_1   = s2_v_q[1];
        assign addr_err_1 = s2_e_q[1];
    end else begin : g_lat1
        assign rdata_0    = s1_d_q[0];
        assign rvalid_0   = s1_v_q[0];
        assign addr_err_0 = s1_e_q[0];
        assign rdata_1    = s1_d_q[1];
        assign rvalid_1   = s1_v_q[1];
        assign addr_err_1 = s1_e_q[1];
    end

endmodule

// File: tb/tb_ram_dp_sync_be.sv
// Bench for ram_dp_sync_be: two configurations share one stimulus stream and are
// checked against a cycle-level reference model of the memory and read pipeline.
module tb_ram_dp_sync_be;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs   [2];
    logic        we   [2];
    logic [3:0]  be   [2];
    logic [7:0]  addr [2];
    logic [31:0] wd   [2];

    logic [31:0] o_rd  [2][2];
    logic        o_rv  [2][2];
    logic        o_er  [2][2];
    logic        o_col [2];
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    // Index 0: depth 200, latency 1, write-first, 4-bit counter; index 1: 256, 2, read-old, 16-bit
    int DEPTH [2] = '{200, 256};
    int LAT   [2] = '{1, 2};
    int RDW   [2] = '{1, 0};
    int CMAX  [2] = '{15, 65535};

    logic [31:0] mm    [2][256];
    logic        rv_r  [2][2][4];
    logic        er_r  [2][2][4];
    logic [31:0] rd_r  [2][2][4];
    logic [31:0] e_rd  [2][2];
    logic        e_rv  [2][2];
    logic        e_er  [2][2];
    logic        e_col [2];
    int          e_cnt [2];
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    ram_dp_sync_be #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(200), .RD_LATENCY(1),
                     .RDW_MODE(1), .CNT_WIDTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .cs_0(cs[0]), .we_0(we[0]), .be_0(be[0]), .address_0(addr[0]), .wdata_0(wd[0]),
        .rdata_0(o_rd[0][0]), .rvalid_0(o_rv[0][0]), .addr_err_0(o_er[0][0]),
        .cs_1(cs[1]), .we_1(we[1]), .be_1(be[1]), .address_1(addr[1]), .wdata_1(wd[1]),
        .rdata_1(o_rd[0][1]), .rvalid_1(o_rv[0][1]), .addr_err_1(o_er[0][1]),
        .collision(o_col[0]), .coll_cnt(cnt_a)
    );

    ram_dp_sync_be #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(256), .RD_LATENCY(2),
                     .RDW_MODE(0), .CNT_WIDTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .cs_0(cs[0]), .we_0(we[0]), .be_0(be[0]), .address_0(addr[0]), .wdata_0(wd[0]),
        .rdata_0(o_rd[1][0]), .rvalid_0(o_rv[1][0]), .addr_err_0(o_er[1][0]),
        .cs_1(cs[1]), .we_1(we[1]), .be_1(be[1]), .address_1(addr[1]), .wdata_1(wd[1]),
        .rdata_1(o_rd[1][1]), .rvalid_1(o_rv[1][1]), .addr_err_1(o_er[1][1]),
        .collision(o_col[1]), .coll_cnt(cnt_b)
    );

    task automatic set_idle();
        for (int p = 0; p < 2; p++) begin
            cs[p] = 1'b0; we[p] = 1'b0; be[p] = 4'h0; addr[p] = 8'h0; wd[p] = 32'h0;
        end
    endtask

    task automatic drive(input int p, input logic w, input logic [3:0] b,
                         input logic [7:0] a, input logic [31:0] d);
        cs[p] = 1'b1; we[p] = w; be[p] = b; addr[p] = a; wd[p] = d;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                e_rd[k][p] = 32'h0; e_rv[k][p] = 1'b0; e_er[k][p] = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    rv_r[k][p][s] = 1'b0; er_r[k][p][s] = 1'b0; rd_r[k][p][s] = 32'h0;
                end
            end
            e_col[k] = 1'b0;
            e_cnt[k] = 0;
        end
    endtask

    // One clock edge: the model applies the access rules, then outputs settle by the negedge
    task automatic tick();
        logic        inr [2];
        logic        av  [2];
        logic        ae  [2];
        logic [31:0] ad  [2];
        logic        col;
        int unsigned ri;
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    inr[p] = int'(addr[p]) < DEPTH[k];
                    av[p]  = cs[p] && !we[p];
                    ae[p]  = cs[p] && !inr[p];
                    ad[p]  = (av[p] && inr[p]) ? mm[k][addr[p]] : 32'h0;
                end
                col = cs[0] && we[0] && cs[1] && we[1] && inr[0] && inr[1] && (addr[0] == addr[1]);
                for (int p = 1; p >= 0; p--)
                    if (cs[p] && we[p] && inr[p])
                        for (int b = 0; b < 4; b++)
                            if (be[p][b]) mm[k][addr[p]][8*b +: 8] = wd[p][8*b +: 8];
                for (int p = 0; p < 2; p++)
                    if (RDW[k] == 1 && cs[p] && we[p]) begin
                        av[p] = 1'b1;
                        ad[p] = inr[p] ? mm[k][addr[p]] : 32'h0;
                    end
                for (int p = 0; p < 2; p++) begin
                    rv_r[k][p][cyc % 4] = av[p];
                    er_r[k][p][cyc % 4] = ae[p];
                    rd_r[k][p][cyc % 4] = ad[p];
                    ri = (cyc + 5 - LAT[k]) % 4;
                    e_rv[k][p] = rv_r[k][p][ri];
                    e_er[k][p] = er_r[k][p][ri];
                    if (rv_r[k][p][ri]) e_rd[k][p] = rd_r[k][p][ri];
                end
                e_col[k] = col;
                if (col && e_cnt[k] < CMAX[k]) e_cnt[k]++;
            end
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                checks++; if (o_rd[k][p] !== 32'h0) begin failures++; $display("FAIL reset_rdata k%0d p%0d got=%h exp=0", k, p, o_rd[k][p]); end
                checks++; if (o_rv[k][p] !== 1'b0) begin failures++; $display("FAIL reset_rvalid k%0d p%0d got=%b exp=0", k, p, o_rv[k][p]); end
                checks++; if (o_er[k][p] !== 1'b0) begin failures++; $display("FAIL reset_err k%0d p%0d got=%b exp=0", k, p, o_er[k][p]); end
            end
            checks++; if (o_col[k] !== 1'b0) begin failures++; $display("FAIL reset_coll k%0d got=%b exp=0", k, o_col[k]); end
        end
        checks++; if (cnt_a !== 4'h0 || cnt_b !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", cnt_a, cnt_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 128; i++) begin
            drive(0, 1'b1, 4'hF, 8'(2*i), $urandom);
            drive(1, 1'b1, 4'hF, 8'(2*i+1), $urandom);
            tick();
        end
        set_idle();
    endtask

    task automatic test_basic();
        set_idle(); drive(0, 1'b1, 4'hF, 8'd5, 32'hDEADBEEF); tick();
        set_idle(); drive(1, 1'b0, 4'h0, 8'd5, 32'h0); tick();
        checks++; if (o_rd[0][1] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rdata1 got=%h exp=deadbeef", o_rd[0][1]); end
        checks++; if (o_rv[0][1] !== 1'b1) begin failures++; $display("FAIL basic_rvalid1 got=%b exp=1", o_rv[0][1]); end
        checks++; if (o_rv[1][1] !== 1'b0) begin failures++; $display("FAIL basic_lat2_early got=%b exp=0", o_rv[1][1]); end
        set_idle(); tick();
        checks++; if (o_rv[0][1] !== 1'b0) begin failures++; $display("FAIL basic_rvalid_pulse got=%b exp=0", o_rv[0][1]); end
        checks++; if (o_rd[0][1] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_hold got=%h exp=deadbeef", o_rd[0][1]); end
        checks++; if (o_rv[1][1] !== 1'b1 || o_rd[1][1] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_lat2 got=%b/%h exp=1/deadbeef", o_rv[1][1], o_rd[1][1]); end
    endtask

    task automatic test_byte_en();
        set_idle(); drive(0, 1'b1, 4'hF, 8'd3, 32'h11223344); tick();
        set_idle(); drive(0, 1'b1, 4'b0101, 8'd3, 32'hAABBCCDD); tick();
        set_idle(); drive(0, 1'b0, 4'h0, 8'd3, 32'h0); tick();
        checks++; if (o_rd[0][0] !== 32'h11BB33DD) begin failures++; $display("FAIL byte_en_a got=%h exp=11bb33dd", o_rd[0][0]); end
        set_idle(); tick();
        checks++; if (o_rd[1][0] !== 32'h11BB33DD) begin failures++; $display("FAIL byte_en_b got=%h exp=11bb33dd", o_rd[1][0]); end
        set_idle(); drive(1, 1'b1, 4'h0, 8'd3, 32'hFFFFFFFF); tick();
        set_idle(); drive(1, 1'b0, 4'hF, 8'd3, 32'h0); tick();
        checks++; if (o_rd[0][1] !== 32'h11BB33DD) begin failures++; $display("FAIL byte_en_zero got=%h exp=11bb33dd", o_rd[0][1]); end
        set_idle(); tick();
    endtask

    task automatic test_collision();
        do_reset();
        drive(0, 1'b1, 4'b0001, 8'd9, 32'h000000FF);
        drive(1, 1'b1, 4'b1111, 8'd9, 32'hAAAAAA00);
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_col[k] !== 1'b1) begin failures++; $display("FAIL coll_pulse k%0d got=%b exp=1", k, o_col[k]); end
        end
        checks++; if (cnt_a !== 4'd1 || cnt_b !== 16'd1) begin failures++; $display("FAIL coll_cnt1 got=%0d/%0d exp=1/1", cnt_a, cnt_b); end
        set_idle(); tick();
        checks++; if (o_col[0] !== 1'b0) begin failures++; $display("FAIL coll_pulse_end got=%b exp=0", o_col[0]); end
        drive(0, 1'b0, 4'h0, 8'd9, 32'h0); tick();
        checks++; if (o_rd[0][0] !== 32'hAAAAAAFF) begin failures++; $display("FAIL coll_merge_a got=%h exp=aaaaaaff", o_rd[0][0]); end
        set_idle(); tick();
        checks++; if (o_rd[1][0] !== 32'hAAAAAAFF) begin failures++; $display("FAIL coll_merge_b got=%h exp=aaaaaaff", o_rd[1][0]); end
        drive(0, 1'b1, 4'b0001, 8'd9, 32'h000000FF);
        drive(1, 1'b1, 4'b1111, 8'd9, 32'hAAAAAA00);
        repeat (20) tick();
        checks++; if (cnt_a !== 4'hF) begin failures++; $display("FAIL coll_saturate got=%h exp=f", cnt_a); end
        checks++; if (cnt_b !== 16'd21) begin failures++; $display("FAIL coll_cnt21 got=%0d exp=21", cnt_b); end
        set_idle(); tick();
    endtask

    task automatic test_rdw();
        drive(0, 1'b1, 4'hF, 8'd2, 32'h1); tick();
        set_idle();
        drive(0, 1'b1, 4'hF, 8'd2, 32'h2);
        drive(1, 1'b0, 4'h0, 8'd2, 32'h0);
        tick();
        checks++; if (o_rd[0][1] !== 32'h1) begin failures++; $display("FAIL rdw_cross_old got=%h exp=1", o_rd[0][1]); end
        checks++; if (o_rv[0][0] !== 1'b1 || o_rd[0][0] !== 32'h2) begin failures++; $display("FAIL rdw_wfirst got=%b/%h exp=1/2", o_rv[0][0], o_rd[0][0]); end
        set_idle(); tick();
        checks++; if (o_rd[1][1] !== 32'h1) begin failures++; $display("FAIL rdw_cross_old_b got=%h exp=1", o_rd[1][1]); end
        checks++; if (o_rv[1][0] !== 1'b0) begin failures++; $display("FAIL rdw_readold_novalid got=%b exp=0", o_rv[1][0]); end
        drive(1, 1'b0, 4'h0, 8'd2, 32'h0); tick();
        checks++; if (o_rd[0][1] !== 32'h2) begin failures++; $display("FAIL rdw_next_read got=%h exp=2", o_rd[0][1]); end
        set_idle(); drive(0, 1'b1, 4'hF, 8'd2, 32'h3); tick();
        checks++; if (o_rv[0][0] !== 1'b1 || o_rd[0][0] !== 32'h3) begin failures++; $display("FAIL rdw_same_port got=%b/%h exp=1/3", o_rv[0][0], o_rd[0][0]); end
        set_idle(); tick();
    endtask

    task automatic test_pipeline();
        logic [31:0] val [8];
        for (int i = 0; i < 8; i++) begin
            val[i] = 32'h5000_0000 + 32'(i) * 32'h0001_0203;
            set_idle(); drive(0, 1'b1, 4'hF, 8'(i), val[i]); tick();
        end
        for (int i = 0; i < 10; i++) begin
            set_idle();
            if (i < 8) drive(0, 1'b0, 4'h0, 8'(i), 32'h0);
            tick();
            checks++; if (o_rv[1][0] !== ((i >= 1) && (i <= 8))) begin failures++; $display("FAIL pipe_rvalid i%0d got=%b", i, o_rv[1][0]); end
            if (i >= 1 && i <= 8) begin
                checks++; if (o_rd[1][0] !== val[i-1]) begin failures++; $display("FAIL pipe_data i%0d got=%h exp=%h", i, o_rd[1][0], val[i-1]); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            set_idle(); drive(0, 1'b0, 4'h0, 8'(i), 32'h0); tick();
        end
        rst_n = 1'b0;
        #1;
        checks++; if (o_rv[1][0] !== 1'b0 || o_rd[1][0] !== 32'h0) begin failures++; $display("FAIL pipe_async_rst got=%b/%h exp=0/0", o_rv[1][0], o_rd[1][0]); end
        checks++; if (o_rv[0][0] !== 1'b0) begin failures++; $display("FAIL pipe_async_rst_a got=%b exp=0", o_rv[0][0]); end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_rv[1][0] !== 1'b0) begin failures++; $display("FAIL pipe_flushed i%0d got=%b exp=0", i, o_rv[1][0]); end
        end
    endtask

    task automatic test_oor();
        set_idle(); drive(0, 1'b0, 4'h0, 8'd250, 32'h0); tick();
        checks++; if (o_rd[0][0] !== 32'h0 || o_rv[0][0] !== 1'b1 || o_er[0][0] !== 1'b1) begin failures++; $display("FAIL oor_read got=%h/%b/%b exp=0/1/1", o_rd[0][0], o_rv[0][0], o_er[0][0]); end
        set_idle(); tick();
        checks++; if (o_er[0][0] !== 1'b0) begin failures++; $display("FAIL oor_err_pulse got=%b exp=0", o_er[0][0]); end
        checks++; if (o_er[1][0] !== 1'b0 || o_rv[1][0] !== 1'b1) begin failures++; $display("FAIL oor_inrange_b got=%b/%b exp=0/1", o_er[1][0], o_rv[1][0]); end
        drive(0, 1'b1, 4'hF, 8'd250, 32'h12345678);
        drive(1, 1'b1, 4'hF, 8'd250, 32'h9ABCDEF0);
        tick();
        checks++; if (o_col[0] !== 1'b0 || o_col[1] !== 1'b1) begin failures++; $display("FAIL oor_no_coll got=%b/%b exp=0/1", o_col[0], o_col[1]); end
        checks++; if (o_er[0][1] !== 1'b1) begin failures++; $display("FAIL oor_write_err got=%b exp=1", o_er[0][1]); end
        set_idle(); drive(0, 1'b0, 4'h0, 8'd50, 32'h0); tick();
        checks++; if (o_rd[0][0] !== mm[0][50]) begin failures++; $display("FAIL oor_no_alias got=%h exp=%h", o_rd[0][0], mm[0][50]); end
        set_idle(); tick();
    endtask

    task automatic test_random();
        int obs_cnt;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            for (int p = 0; p < 2; p++) begin
                cs[p]   = ($urandom_range(0, 3) != 0);
                we[p]   = $urandom_range(0, 1) == 1;
                be[p]   = 4'($urandom_range(0, 15));
                addr[p] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                wd[p]   = $urandom;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++; if (o_rv[k][p] !== e_rv[k][p]) begin failures++; $display("FAIL rnd_rvalid c%0d k%0d p%0d got=%b exp=%b", i, k, p, o_rv[k][p], e_rv[k][p]); end
                    checks++; if (o_er[k][p] !== e_er[k][p]) begin failures++; $display("FAIL rnd_err c%0d k%0d p%0d got=%b exp=%b", i, k, p, o_er[k][p], e_er[k][p]); end
                    checks++; if (o_rd[k][p] !== e_rd[k][p]) begin failures++; $display("FAIL rnd_rdata c%0d k%0d p%0d got=%h exp=%h", i, k, p, o_rd[k][p], e_rd[k][p]); end
                end
                obs_cnt = (k == 0) ? int'(cnt_a) : int'(cnt_b);
                checks++; if (o_col[k] !== e_col[k]) begin failures++; $display("FAIL rnd_coll c%0d k%0d got=%b exp=%b", i, k, o_col[k], e_col[k]); end
                checks++; if (obs_cnt !== e_cnt[k]) begin failures++; $display("FAIL rnd_cnt c%0d k%0d got=%0d exp=%0d", i, k, obs_cnt, e_cnt[k]); end
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_byte_en();
        test_collision();
        test_rdw();
        test_pipeline();
        test_oor();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
